pipelined_adder: RTL and testbench

- Parametrised, pipelined, registered successor to the combinational ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES equal ripple slices with the carry registered between slices, so the clock rate is set by one slice rather than the full chain.
- Carries a valid/ready handshake with backpressure and an add/subtract mode.
- Serves as the arithmetic building block for the wider datapath labs.

---
 rtl/pipelined_adder_pkg.sv | 15 +
 rtl/adder_slice.sv | 30 +++
 rtl/full_adder.sv | 13 +
 rtl/pipelined_adder.sv | 107 ++++++++++
 tb/tb_pipelined_adder.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: shared constants and parameter helpers for pipelined_adder.
package pipelined_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        return stages >= 1 && stages <= width && width % stages == 0;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: CW-bit ripple chain of full adders; also exposes the carry into its MSB.
module adder_slice #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co,
    output logic          c_msb
);

    logic [CW:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CW; i++) begin : gen_fa
        full_adder u_fa (
            .a (a[i]),
            .b (b[i]),
            .ci(c[i]),
            .s (s[i]),
            .co(c[i+1])
        );
    end

    assign co    = c[CW];
    assign c_msb = c[CW-1];

endmodule

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep registered ripple add/subtract with valid/ready backpressure.
// Define PIPELINED_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = slice_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : gen_cfg_err
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    // Each stage consumes the low CW bits of its operand words; the A word rotates
    // right and the new sum slice enters at the top, so after STAGES stages it holds S.
    logic             advance;
    logic [WIDTH-1:0] a_i [STAGES];
    logic [WIDTH-1:0] b_i [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [CW-1:0]    sum [STAGES];
    logic [STAGES-1:0] c_i, v_i, c_q, v_q, co_s, cm_s;
    logic             unused_b;

    assign advance   = ~v_q[STAGES-1] | out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[STAGES-1];
    assign S         = a_q[STAGES-1];
    assign Co        = c_q[STAGES-1];
    assign unused_b  = ^b_q[STAGES-1];

    always_comb begin
        a_i[0] = A;
        b_i[0] = (sub == OP_SUB) ? ~B : B;
        c_i[0] = (sub == OP_ADD) ? Ci : 1'b1;
        v_i[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_i[k] = a_q[k-1];
            b_i[k] = b_q[k-1];
            c_i[k] = c_q[k-1];
            v_i[k] = v_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        adder_slice #(.CW(CW)) u_slice (
            .a    (a_i[k][CW-1:0]),
            .b    (b_i[k][CW-1:0]),
            .ci   (c_i[k]),
            .s    (sum[k]),
            .co   (co_s[k]),
            .c_msb(cm_s[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            c_q <= '0;
            v_q <= '0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= (a_i[k] >> CW) | (WIDTH'(sum[k]) << (WIDTH - CW));
                b_q[k] <= b_i[k] >> CW;
            end
            c_q <= co_s;
            v_q <= v_i;
        end
    end

`ifdef PIPELINED_ADDER_OVF_EN
    logic unused_cm;
    assign unused_cm = ^cm_s;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (advance)
            ovf <= co_s[STAGES-1] ^ cm_s[STAGES-1];
    end
`else
    logic unused_cm;
    assign unused_cm = ^cm_s;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: WIDTH=8 adders at STAGES 1,2,4,8 checked against an arithmetic scoreboard.
// Honours PIPELINED_ADDER_OVF_EN to also check ovf.
module tb_pipelined_adder;

    logic       clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, ci = 0, sub = 0;
    logic [7:0] a = 0, b = 0;
    logic       in_r [4];
    logic       o_v  [4];
    logic       o_co [4];
    logic [7:0] o_s  [4];
`ifdef PIPELINED_ADDER_OVF_EN
    logic       o_ovf [4];
    localparam logic [9:0] MASK = 10'h3FF;
`else
    localparam logic [9:0] MASK = 10'h1FF;
`endif
    int n_chk = 0, n_fail = 0;
    int n_in [4], n_out [4];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {ovf, Co, S} straight from two's-complement arithmetic
    function automatic logic [9:0] ref_res(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s);
        int sx, sy, r;
        logic [8:0] u;
        sx = $signed(x);
        sy = $signed(y);
        if (s) begin
            u = {1'b0, x} + (9'h100 - {1'b0, y});
            r = sx - sy;
        end else begin
            u = {1'b0, x} + {1'b0, y} + {8'b0, c};
            r = sx + sy + (c ? 1 : 0);
        end
        return {r > 127 || r < -128, u};
    endfunction

    function automatic logic [9:0] obs(input int i);
`ifdef PIPELINED_ADDER_OVF_EN
        return {o_ovf[i], o_co[i], o_s[i]};
`else
        return {1'b0, o_co[i], o_s[i]};
`endif
    endfunction

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        localparam int ST = 1 << g;
        logic [9:0] q [$];
        pipelined_adder #(.WIDTH(8), .STAGES(ST)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_r[g]),
            .A        (a),
            .B        (b),
            .Ci       (ci),
            .sub      (sub),
            .out_valid(o_v[g]),
            .out_ready(out_ready),
            .S        (o_s[g]),
            .Co       (o_co[g])
`ifdef PIPELINED_ADDER_OVF_EN
            ,
            .ovf      (o_ovf[g])
`endif
        );
        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                n_in[g] = n_out[g];
            end else begin
                if (o_v[g] && out_ready) begin
                    if (q.size() == 0)
                        chk($sformatf("sb_extra_st%0d", ST), n_out[g] + 1, n_in[g]);
                    else
                        chk($sformatf("sb_st%0d", ST), obs(g), q.pop_front() & MASK);
                    n_out[g]++;
                end
                if (in_valid && in_r[g]) begin
                    q.push_back(ref_res(a, b, ci, sub));
                    n_in[g]++;
                end
            end
        end
    end

    // One transaction into an empty pipeline; each instance must answer exactly STAGES cycles later.
    task automatic run_one(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                           input logic tci, input logic tsub, input logic [9:0] exp);
        a = ta; b = tb_v; ci = tci; sub = tsub; in_valid = 1; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        for (int k = 1; k <= 9; k++) begin
            for (int i = 0; i < 4; i++) begin
                chk({tag, "_valid"}, o_v[i], k == (1 << i));
                if (k == (1 << i)) chk(tag, obs(i), exp & MASK);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        #3;
        for (int i = 0; i < 4; i++) begin
            chk("rst_valid", o_v[i], 0);
            chk("rst_in_ready", in_r[i], 1);
            chk("rst_co_s", {o_co[i], o_s[i]}, 0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        run_one("carry", 8'hFF, 8'h01, 1'b0, 1'b0, 10'h100);
        run_one("sub", 8'h05, 8'h07, 1'b1, 1'b1, 10'h0FE);
`ifdef PIPELINED_ADDER_OVF_EN
        run_one("ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 10'h280);
`endif
        for (int c = 0; c < 13; c++) begin
            in_valid = c < 4; a = 8'(16 * (c + 1)); b = 8'(c + 1); ci = 0; sub = 0;
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                int j;
                j = c + 1 - (1 << i);
                chk("b2b_valid", o_v[i], j >= 0 && j < 4);
                if (j >= 0 && j < 4) chk("b2b_s", obs(i), 10'(17 * (j + 1)));
            end
        end
        for (int c = 0; c < 7; c++) begin
            in_valid = c < 4; a = 8'(16 * (c + 1)); b = 8'(c + 1);
            out_ready = !(c >= 2 && c < 5);
            @(posedge clk); #1;
            if (c >= 2 && c < 5) begin
                chk("bp_valid", o_v[1], 1);
                chk("bp_s_held", o_s[1], 8'h11);
                chk("bp_in_ready", in_r[1], 0);
            end
        end
        in_valid = 0; out_ready = 1;
        repeat (12) @(posedge clk);
        #1;
        in_valid = 1; a = 8'hAA; b = 8'h11; out_ready = 0;
        @(posedge clk); #1;
        a = 8'hCC;
        @(posedge clk); #1;
        in_valid = 0; rst_n = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("midrst_valid", o_v[i], 0);
            chk("midrst_in_ready", in_r[i], 1);
            chk("midrst_co_s", {o_co[i], o_s[i]}, 0);
        end
        @(posedge clk); #1;
        rst_n = 1;
        run_one("post_rst", 8'h3C, 8'h0F, 1'b1, 1'b0, 10'h04C);
        repeat (20000) begin
            a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom); sub = 1'($urandom);
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            @(posedge clk); #1;
        end
        in_valid = 0; out_ready = 1;
        repeat (12) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk("drained", n_out[i], n_in[i]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
